iter_compare_n: RTL and testbench

- Multi-cycle, parametrised integer comparator. Generalises the single-cycle signed less-than block to selectable signed/unsigned and equality modes.
- Operands are processed CHUNK bits per cycle, LSB first, through a chunk-wide subtract (a + ~b + carry) with a carry register. This trades latency for a narrow adder.
- Sits beside the ALU and branch unit. Uses a valid/ready handshake on input and output.

---
 rtl/iter_compare_n_if.sv | 26 ++
 rtl/iter_compare_n.sv | 120 ++++++++++++
 tb/tb_iter_compare_n.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_compare_n_if.sv
// Request/response bundle for iter_compare_n.
// The master drives the request and accepts the result. The slave is the comparator.
interface iter_compare_n_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic         result;
    logic [2:0]   flags;
    logic         illegal;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, flags, illegal
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, flags, illegal
    );
endinterface

// File: rtl/iter_compare_n.sv
// Multi-cycle integer comparator.
// Operands are walked LSB chunk first through a CHUNK-wide a + ~b + carry subtractor.
// The result covers signed/unsigned less-than, equality and their complements.
// flags = {eq, lt_signed, lt_unsigned} is always reported. Modes 6/7 complete with illegal=1.
module iter_compare_n #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst,
    iter_compare_n_if.slave   bus
);
    localparam int NCH = N / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = CHUNK + 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    a_sh, b_sh;
    logic [2:0]      mode_q;
    logic [IW-1:0]   idx;
    logic            carry, eq_acc;
    logic            result_q, illegal_q;
    logic [2:0]      flags_q;

    logic [CHUNK-1:0] a_k, b_k, s_k;
    logic [CHUNK:0]   sum;
    logic             c_k, last;
    logic             eq_f, lts_f, ltu_f, res_f;

    // Chunk subtractor and final-result decode for the chunk currently at the bottom of the shifters
    always_comb begin
        a_k   = a_sh[CHUNK-1:0];
        b_k   = b_sh[CHUNK-1:0];
        sum   = {1'b0, a_k} + {1'b0, ~b_k} + CW'(carry);
        c_k   = sum[CHUNK];
        s_k   = sum[CHUNK-1:0];
        last  = (idx == LAST);
        eq_f  = eq_acc & (a_k == b_k);
        ltu_f = ~c_k;
        // On the last chunk the chunk MSBs are the operand sign bits.
        // Differing signs decide directly, so the subtract cannot overflow the answer.
        lts_f = (a_k[CHUNK-1] ^ b_k[CHUNK-1]) ? a_k[CHUNK-1] : s_k[CHUNK-1];
        case (mode_q)
            3'd0:    res_f = lts_f;
            3'd1:    res_f = ltu_f;
            3'd2:    res_f = eq_f;
            3'd3:    res_f = ~eq_f;
            3'd4:    res_f = ~lts_f;
            3'd5:    res_f = ~ltu_f;
            default: res_f = 1'b0;
        endcase
    end

    // Next-state and handshake outputs. The ready and valid signals decode only the state register.
    always_comb begin
        state_nx      = state;
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = BUSY;
            BUSY:    if (last)          state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operand latch, chunk walk, and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            mode_q    <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            eq_acc    <= 1'b0;
            result_q  <= 1'b0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        mode_q <= bus.mode;
                        carry  <= 1'b1;
                        eq_acc <= 1'b1;
                        idx    <= '0;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> CHUNK;
                    b_sh   <= b_sh >> CHUNK;
                    carry  <= c_k;
                    eq_acc <= eq_f;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        result_q  <= res_f;
                        flags_q   <= {eq_f, lts_f, ltu_f};
                        illegal_q <= mode_q[2] & mode_q[1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.flags   = flags_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_iter_compare_n.sv
// Scoreboard bench for iter_compare_n.
// One N=32/CHUNK=8 instance gets directed vectors, backpressure and a mid-operation reset.
// Four N=8 instances (CHUNK=1,2,4,8) get a 16x16 operand sweep checked against a reference model.
module tb_iter_compare_n;
    typedef struct {
        logic       res;
        logic [2:0] fl;
        logic       ill;
        int         lat;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_m, rst_s;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    exp_t q [5][$];
    logic ov [5], ordy [5], irdy [5], ores [5], oill [5];
    logic [2:0] ofl [5];
    bit   drv_done [5];
    bit   drv_tmo [5];
    bit   go_s = 1'b0;
    bit   end_req = 1'b0, end_ack = 1'b0;
    int   rchk_req = 0, rchk_seen = 0;
    logic [4:0] rchk_mask = '0;

    logic [7:0] ops [16] = '{8'h00, 8'h01, 8'h02, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'hFE,
                             8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h10, 8'hEF, 8'h3C};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ref_res(input logic [2:0] md, input logic eq, input logic lts, input logic ltu);
        case (md)
            3'd0:    return lts;
            3'd1:    return ltu;
            3'd2:    return eq;
            3'd3:    return !eq;
            3'd4:    return !lts;
            3'd5:    return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- main instance ----------------
    iter_compare_n_if #(.N(32)) mbus ();
    iter_compare_n #(.N(32), .CHUNK(8)) dut (.clk(clk), .rst(rst_m), .bus(mbus));
    assign ov[4] = mbus.out_valid;
    assign ordy[4] = mbus.out_ready;
    assign irdy[4] = mbus.in_ready;
    assign ores[4] = mbus.result;
    assign ofl[4] = mbus.flags;
    assign oill[4] = mbus.illegal;

    // ---------------- sweep instances ----------------
    for (genvar g = 0; g < 4; g++) begin : sw
        localparam int CH = 1 << g;
        iter_compare_n_if #(.N(8)) bus ();
        iter_compare_n #(.N(8), .CHUNK(CH)) dut (.clk(clk), .rst(rst_s), .bus(bus));
        assign ov[g] = bus.out_valid;
        assign ordy[g] = bus.out_ready;
        assign irdy[g] = bus.in_ready;
        assign ores[g] = bus.result;
        assign ofl[g] = bus.flags;
        assign oill[g] = bus.illegal;
        assign bus.out_ready = 1'b1;

        initial begin : drv
            logic [7:0] va, vb;
            logic [2:0] md;
            logic eq, lts, ltu;
            int t;
            exp_t e;
            bus.in_valid = 1'b0;
            bus.a = '0;
            bus.b = '0;
            bus.mode = '0;
            wait (go_s);
            @(posedge clk); #1;
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    va = ops[i];
                    vb = ops[j];
                    md = 3'((i * 16 + j) % 8);
                    t = 0;
                    while (bus.in_ready !== 1'b1 && t < 100) begin
                        @(posedge clk); #1; t++;
                    end
                    if (t >= 100) begin
                        drv_tmo[g] = 1'b1;
                        break;
                    end
                    bus.in_valid = 1'b1;
                    bus.a = va;
                    bus.b = vb;
                    bus.mode = md;
                    @(posedge clk); #1;
                    bus.in_valid = 1'b0;
                    bus.a = ~va;
                    bus.b = ~vb;
                    bus.mode = ~md;
                    eq  = (va == vb);
                    lts = ($signed(va) < $signed(vb));
                    ltu = (va < vb);
                    e.res = ref_res(md, eq, lts, ltu);
                    e.fl  = {eq, lts, ltu};
                    e.ill = (md >= 3'd6);
                    e.lat = 8 / CH;
                    e.acc = cyc;
                    q[g].push_back(e);
                end
                if (drv_tmo[g]) break;
            end
            drv_done[g] = 1'b1;
        end
    end

    // ---------------- scoreboard monitor ----------------
    bit pres [5];
    bit post [5];
    logic hres [5], hill [5];
    logic [2:0] hfl [5];

    function automatic void chk(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0h expected %0h at cycle %0d", name, g, got, exp, cyc);
        end
    endfunction

    // Pop and compare whenever an instance presents a result, then check hold, reset and end-of-run state
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 5; g++) begin
            if (post[g]) begin
                post[g] = 1'b0;
                chk("in_ready_after", g, 32'(irdy[g]), 32'd1);
                chk("valid_after", g, 32'(ov[g]), 32'd0);
            end
            if (ov[g] === 1'b1) begin
                if (!pres[g]) begin
                    pres[g] = 1'b1;
                    hres[g] = ores[g];
                    hfl[g] = ofl[g];
                    hill[g] = oill[g];
                    chk("outstanding", g, 32'(q[g].size() > 0), 32'd1);
                    if (q[g].size() > 0) begin
                        e = q[g][0];
                        chk("result", g, 32'(ores[g]), 32'(e.res));
                        chk("flags", g, 32'(ofl[g]), 32'(e.fl));
                        chk("illegal", g, 32'(oill[g]), 32'(e.ill));
                        chk("latency", g, 32'(cyc - e.acc), 32'(e.lat));
                    end
                end else begin
                    chk("hold_result", g, 32'(ores[g]), 32'(hres[g]));
                    chk("hold_flags", g, 32'(ofl[g]), 32'(hfl[g]));
                    chk("hold_illegal", g, 32'(oill[g]), 32'(hill[g]));
                    chk("stall_in_ready", g, 32'(irdy[g]), 32'd0);
                end
                if (ordy[g] === 1'b1) begin
                    if (q[g].size() > 0) void'(q[g].pop_front());
                    pres[g] = 1'b0;
                    post[g] = 1'b1;
                end
            end
        end
        if (rchk_req != rchk_seen) begin
            rchk_seen = rchk_req;
            for (int g = 0; g < 5; g++) begin
                if (rchk_mask[g]) begin
                    chk("rst_in_ready", g, 32'(irdy[g]), 32'd1);
                    chk("rst_out_valid", g, 32'(ov[g]), 32'd0);
                    chk("rst_result", g, 32'(ores[g]), 32'd0);
                    chk("rst_flags", g, 32'(ofl[g]), 32'd0);
                    chk("rst_illegal", g, 32'(oill[g]), 32'd0);
                end
            end
        end
        if (end_req && !end_ack) begin
            for (int g = 0; g < 5; g++) begin
                chk("driver_done", g, 32'(drv_done[g] && !drv_tmo[g]), 32'd1);
                chk("queue_empty", g, 32'(q[g].size()), 32'd0);
            end
            end_ack = 1'b1;
        end
    end

    // ---------------- main directed driver ----------------
    task automatic issue_m(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] md,
                           input logic er, input logic [2:0] ef, input logic ei, input bit push);
        int t;
        exp_t e;
        t = 0;
        while (mbus.in_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 100) begin
            drv_tmo[4] = 1'b1;
            return;
        end
        mbus.in_valid = 1'b1;
        mbus.a = va;
        mbus.b = vb;
        mbus.mode = md;
        @(posedge clk); #1;
        mbus.in_valid = 1'b0;
        mbus.a = ~va;
        mbus.b = ~vb;
        mbus.mode = 3'd2;
        if (push) begin
            e.res = er;
            e.fl  = ef;
            e.ill = ei;
            e.lat = 4;
            e.acc = cyc;
            q[4].push_back(e);
        end
    endtask

    initial begin
        int t;
        mbus.in_valid = 1'b0;
        mbus.a = '0;
        mbus.b = '0;
        mbus.mode = '0;
        mbus.out_ready = 1'b1;
        rst_m = 1'b1;
        rst_s = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_m = 1'b0;
        rst_s = 1'b0;
        rchk_mask = 5'b11111;
        rchk_req++;
        @(posedge clk); #1;
        go_s = 1'b1;

        issue_m(32'hFFFFFFFF, 32'h00000001, 3'd0, 1'b1, 3'b010, 1'b0, 1'b1);
        issue_m(32'hFFFFFFFF, 32'h00000001, 3'd1, 1'b0, 3'b010, 1'b0, 1'b1);
        issue_m(32'h80000000, 32'h7FFFFFFF, 3'd0, 1'b1, 3'b010, 1'b0, 1'b1);
        issue_m(32'h80000000, 32'h7FFFFFFF, 3'd4, 1'b0, 3'b010, 1'b0, 1'b1);
        issue_m(32'h80000000, 32'h7FFFFFFF, 3'd1, 1'b0, 3'b010, 1'b0, 1'b1);
        issue_m(32'h80000000, 32'h7FFFFFFF, 3'd5, 1'b1, 3'b010, 1'b0, 1'b1);
        issue_m(32'h12345678, 32'h12345678, 3'd2, 1'b1, 3'b100, 1'b0, 1'b1);
        issue_m(32'h12345678, 32'h12345678, 3'd3, 1'b0, 3'b100, 1'b0, 1'b1);
        issue_m(32'h12345679, 32'h12345678, 3'd2, 1'b0, 3'b000, 1'b0, 1'b1);
        issue_m(32'h12345679, 32'h12345678, 3'd4, 1'b1, 3'b000, 1'b0, 1'b1);

        // backpressure: result held for 10 cycles, then released
        issue_m(32'h00000001, 32'h00000002, 3'd1, 1'b1, 3'b011, 1'b0, 1'b1);
        mbus.out_ready = 1'b0;
        t = 0;
        while (mbus.out_valid !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        repeat (10) @(posedge clk);
        #1;
        mbus.out_ready = 1'b1;
        issue_m(32'h7FFFFFFF, 32'h80000000, 3'd0, 1'b0, 3'b001, 1'b0, 1'b1);

        issue_m(32'h00000005, 32'h00000003, 3'd6, 1'b0, 3'b000, 1'b1, 1'b1);
        issue_m(32'h00000003, 32'h00000005, 3'd7, 1'b0, 3'b011, 1'b1, 1'b1);

        // reset while chunk 2 is being processed; that request must never complete
        issue_m(32'h00000001, 32'hFFFFFFFF, 3'd1, 1'b1, 3'b001, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_m = 1'b1;
        @(posedge clk); #1;
        rst_m = 1'b0;
        rchk_mask = 5'b10000;
        rchk_req++;
        repeat (12) @(posedge clk);
        #1;
        issue_m(32'h00000005, 32'h00000005, 3'd2, 1'b1, 3'b100, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        drv_done[4] = 1'b1;

        t = 0;
        while (!(drv_done[0] && drv_done[1] && drv_done[2] && drv_done[3]) && t < 30000) begin
            @(posedge clk); #1; t++;
        end
        repeat (20) @(posedge clk);
        #1;
        end_req = 1'b1;
        t = 0;
        while (!end_ack && t < 10) begin
            @(posedge clk); #1; t++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule
